// File: rtl/pattern_sequencer_if.sv
// rtl/pattern_sequencer_if.sv - control and mode-code bundle between user controls, sequencer and pattern block
interface pattern_sequencer_if #(
    parameter int DWELL_W = 8,
    parameter int PASS_W  = 4
);
    logic               start;
    logic               stop;
    logic               hold;
    logic [DWELL_W-1:0] dwell;
    logic [PASS_W-1:0]  passes;
    logic               a;
    logic               b;
    logic               busy;
    logic               done;
    logic [PASS_W-1:0]  pass_cnt;

    modport master (
        output start, stop, hold, dwell, passes,
        input  a, b, busy, done, pass_cnt
    );

    modport slave (
        input  start, stop, hold, dwell, passes,
        output a, b, busy, done, pass_cnt
    );
endinterface

// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - timed 01->11->10 mode-code sequencer with dwell, hold, stop and pass counting
module pattern_sequencer #(
    parameter int DWELL_W = 8,
    parameter int PASS_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    pattern_sequencer_if.slave seq
);
    // State codes double as the {a,b} mode code driven to the pattern block
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN_B = 2'b01,
        RUN_D = 2'b11,
        RUN_C = 2'b10
    } state_t;

    state_t             state, state_nxt;
    logic [DWELL_W-1:0] timer, timer_nxt;
    logic [DWELL_W-1:0] dwell_l, dwell_l_nxt;
    logic [PASS_W-1:0]  passes_l, passes_l_nxt;
    logic [PASS_W-1:0]  pass_cnt, pass_cnt_nxt;
    logic               busy_q, done_q, done_nxt;
    logic [DWELL_W-1:0] dwell_eff;
    logic [PASS_W-1:0]  pass_inc;

    assign dwell_eff = (seq.dwell == '0) ? DWELL_W'(1) : seq.dwell;
    assign pass_inc  = pass_cnt + PASS_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            timer    <= '0;
            dwell_l  <= DWELL_W'(1);
            passes_l <= '0;
            pass_cnt <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            dwell_l  <= dwell_l_nxt;
            passes_l <= passes_l_nxt;
            pass_cnt <= pass_cnt_nxt;
            busy_q   <= (state_nxt != IDLE);
            done_q   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        dwell_l_nxt  = dwell_l;
        passes_l_nxt = passes_l;
        pass_cnt_nxt = pass_cnt;
        done_nxt     = 1'b0;
        if (state == IDLE) begin
            if (seq.start && !seq.stop) begin
                dwell_l_nxt  = dwell_eff;
                passes_l_nxt = seq.passes;
                timer_nxt    = dwell_eff - DWELL_W'(1);
                pass_cnt_nxt = '0;
                state_nxt    = RUN_B;
            end
        end else if (seq.stop) begin
            state_nxt = IDLE;
            timer_nxt = '0;
        end else if (!seq.hold) begin
            if (timer == '0) begin
                timer_nxt = dwell_l - DWELL_W'(1);
                case (state)
                    RUN_B:   state_nxt = RUN_D;
                    RUN_D:   state_nxt = RUN_C;
                    RUN_C: begin
                        pass_cnt_nxt = pass_inc;
                        // passes_l of zero means run until stopped; the counter simply wraps
                        if (passes_l != '0 && pass_inc == passes_l) begin
                            state_nxt = IDLE;
                            timer_nxt = '0;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = RUN_B;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end else begin
                timer_nxt = timer - DWELL_W'(1);
            end
        end
    end

    assign seq.a        = state[1];
    assign seq.b        = state[0];
    assign seq.busy     = busy_q;
    assign seq.done     = done_q;
    assign seq.pass_cnt = pass_cnt;
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb/tb_pattern_sequencer.sv - directed self-checking bench for pattern_sequencer
module tb_pattern_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    pattern_sequencer_if #(.DWELL_W(8), .PASS_W(4)) sif ();

    pattern_sequencer #(.DWELL_W(8), .PASS_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .seq (sif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Check one observed cycle, then advance to the next sampling point
    task automatic step(input string tag, input logic [1:0] ab, input logic dn);
        check({tag, "_ab"}, {30'd0, sif.a, sif.b}, {30'd0, ab});
        check({tag, "_busy"}, {31'd0, sif.busy}, {31'd0, (ab != 2'b00)});
        check({tag, "_done"}, {31'd0, sif.done}, {31'd0, dn});
        @(negedge clk);
    endtask

    task automatic run_code(input string tag, input logic [1:0] ab, input int n);
        for (int i = 0; i < n; i++) step(tag, ab, 1'b0);
    endtask

    task automatic kick(input logic [7:0] dw, input logic [3:0] ps);
        sif.dwell  = dw;
        sif.passes = ps;
        sif.start  = 1'b1;
        @(negedge clk);
        sif.start  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        sif.start  = 1'b0;
        sif.stop   = 1'b0;
        sif.hold   = 1'b0;
        sif.dwell  = 8'd0;
        sif.passes = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_ab", {30'd0, sif.a, sif.b}, 32'd0);
        check("rst_busy", {31'd0, sif.busy}, 32'd0);
        check("rst_done", {31'd0, sif.done}, 32'd0);
        check("rst_pass", {28'd0, sif.pass_cnt}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        // Hold in IDLE does nothing
        sif.hold = 1'b1;
        @(negedge clk);
        step("idle_hold", 2'b00, 1'b0);
        sif.hold = 1'b0;

        // Basic run: dwell 3, one pass
        kick(8'd3, 4'd1);
        run_code("basic_b", 2'b01, 3);
        run_code("basic_d", 2'b11, 3);
        run_code("basic_c", 2'b10, 3);
        check("basic_pass", {28'd0, sif.pass_cnt}, 32'd1);
        step("basic_end", 2'b00, 1'b1);
        step("basic_after", 2'b00, 1'b0);

        // Dwell zero behaves as one cycle per step, two passes
        kick(8'd0, 4'd2);
        step("dz_b0", 2'b01, 1'b0);
        step("dz_d0", 2'b11, 1'b0);
        step("dz_c0", 2'b10, 1'b0);
        check("dz_pass1", {28'd0, sif.pass_cnt}, 32'd1);
        step("dz_b1", 2'b01, 1'b0);
        step("dz_d1", 2'b11, 1'b0);
        step("dz_c1", 2'b10, 1'b0);
        check("dz_pass2", {28'd0, sif.pass_cnt}, 32'd2);
        step("dz_end", 2'b00, 1'b1);
        step("dz_after", 2'b00, 1'b0);

        // Hold for 5 cycles from the second RUN_D cycle stretches RUN_D to 9
        kick(8'd4, 4'd1);
        run_code("hold_b", 2'b01, 4);
        step("hold_d1", 2'b11, 1'b0);
        check("hold_d2", {30'd0, sif.a, sif.b}, 32'd3);
        sif.hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_frozen", {30'd0, sif.a, sif.b}, 32'd3);
        end
        sif.hold = 1'b0;
        @(negedge clk);
        run_code("hold_d_tail", 2'b11, 2);
        run_code("hold_c", 2'b10, 4);
        step("hold_end", 2'b00, 1'b1);

        // Stop beats hold in RUN_C; no done, pass_cnt kept
        kick(8'd2, 4'd3);
        run_code("stop_b", 2'b01, 2);
        run_code("stop_d", 2'b11, 2);
        check("stop_c", {30'd0, sif.a, sif.b}, 32'd2);
        sif.stop = 1'b1;
        sif.hold = 1'b1;
        @(negedge clk);
        sif.stop = 1'b0;
        sif.hold = 1'b0;
        check("stop_pass", {28'd0, sif.pass_cnt}, 32'd0);
        step("stop_idle", 2'b00, 1'b0);
        step("stop_idle2", 2'b00, 1'b0);
        // Start together with stop in IDLE is refused
        sif.start = 1'b1;
        sif.stop  = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        sif.stop  = 1'b0;
        step("startstop", 2'b00, 1'b0);

        // Continuous run wraps pass_cnt; mid-run start with dwell 7 is ignored
        kick(8'd1, 4'd0);
        for (int k = 0; k < 51; k++) begin
            logic [1:0] code;
            case (k % 3)
                0:       code = 2'b01;
                1:       code = 2'b11;
                default: code = 2'b10;
            endcase
            check("cont_pass", {28'd0, sif.pass_cnt}, 32'((k / 3) % 16));
            if (k == 4) begin
                sif.start = 1'b1;
                sif.dwell = 8'd7;
            end else begin
                sif.start = 1'b0;
            end
            step("cont", code, 1'b0);
        end
        sif.stop = 1'b1;
        @(negedge clk);
        sif.stop = 1'b0;
        step("cont_stopped", 2'b00, 1'b0);

        // Asynchronous reset mid-run in RUN_D, then a normal run
        kick(8'd3, 4'd1);
        run_code("ar_b", 2'b01, 3);
        step("ar_d", 2'b11, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("ar_ab", {30'd0, sif.a, sif.b}, 32'd0);
        check("ar_busy", {31'd0, sif.busy}, 32'd0);
        check("ar_pass", {28'd0, sif.pass_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        kick(8'd2, 4'd1);
        run_code("post_b", 2'b01, 2);
        run_code("post_d", 2'b11, 2);
        run_code("post_c", 2'b10, 2);
        check("post_pass", {28'd0, sif.pass_cnt}, 32'd1);
        step("post_end", 2'b00, 1'b1);
        step("post_after", 2'b00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
